// File: rtl/eer_pkg.sv
// rtl/eer_pkg.sv - shared types and constants for the EER-RL receive path
package eer_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_WIDTH  = 8;
  localparam int MEM_DEPTH  = 2048;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  localparam logic [15:0] HOPS_UNREACHABLE = 16'hFFFF;
  localparam logic [15:0] HOPS_MAX         = 16'hFFFE;

  // Byte counts read per packet: the header word is always fetched with
  // one body word, announcements need three body words.
  localparam logic [3:0] LEN_SHORT    = 4'd4;
  localparam logic [3:0] LEN_ANNOUNCE = 4'd8;

  typedef enum logic [7:0] {
    PKT_HEARTBEAT   = 8'h01,
    PKT_CH_ANNOUNCE = 8'h02
  } pkt_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_HDR,
    ST_FETCH_BODY,
    ST_EMIT,
    ST_FINISH
  } parser_state_e;

  // Hop count seen from this node: one more than the sender, never reaching
  // the unreachable marker.
  function automatic logic [15:0] hops_next(input logic [15:0] sender);
    return (sender >= HOPS_MAX) ? HOPS_MAX : sender + 16'd1;
  endfunction

endpackage

// File: rtl/pkt_word_fetch.sv
// rtl/pkt_word_fetch.sv - pipelined byte reads with address wrap, big-endian word assembly
module pkt_word_fetch
  import eer_pkg::*;
#(
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_DEPTH  = 2048,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [3:0]             len_i,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic                   mem_ren_o,
  input  logic [MEM_WIDTH-1:0]   mem_rdata_i,
  output logic [2*MEM_WIDTH-1:0] word_o,
  output logic                   word_valid_o
);

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   ren_q;
  logic [3:0]             issued_q;
  logic                   rvalid_q;
  logic                   phase_q;
  logic [MEM_WIDTH-1:0]   hi_q;
  logic [2*MEM_WIDTH-1:0] word_q;
  logic                   word_valid_q;

  // Issue one byte address per cycle until len_i bytes are out; len_i may
  // grow while reading once the header type is known.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q   <= '0;
      ren_q    <= 1'b0;
      issued_q <= 4'd0;
    end else if (start_i) begin
      addr_q   <= base_addr_i;
      ren_q    <= 1'b1;
      issued_q <= 4'd1;
    end else if (ren_q) begin
      if (issued_q < len_i) begin
        addr_q   <= (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        issued_q <= issued_q + 4'd1;
      end else begin
        ren_q <= 1'b0;
      end
    end
  end

  // Track read latency and pair bytes MSB-first; a restart discards any
  // reads still in flight from the previous packet.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rvalid_q     <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (start_i) begin
        rvalid_q <= 1'b0;
        phase_q  <= 1'b0;
      end else begin
        rvalid_q <= ren_q;
        if (rvalid_q) begin
          if (!phase_q) begin
            hi_q    <= mem_rdata_i;
            phase_q <= 1'b1;
          end else begin
            word_q       <= {hi_q, mem_rdata_i};
            word_valid_q <= 1'b1;
            phase_q      <= 1'b0;
          end
        end
      end
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_ren_o    = ren_q;
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/rx_pkt_parser.sv
// rtl/rx_pkt_parser.sv - decodes heartbeat / CH announcement packets for the known-CH tracker
module rx_pkt_parser
  import eer_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_DEPTH  = 2048,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  input  logic [MEM_WIDTH-1:0]  mem_rdata,
  output logic                  en_KCH,
  output logic                  HB_reset,
  output logic [WORD_WIDTH-1:0] HB_CHlimit,
  output logic [WORD_WIDTH-1:0] fCH_ID,
  output logic [WORD_WIDTH-1:0] fCH_Hops,
  output logic [WORD_WIDTH-1:0] fCH_QValue,
  output logic                  busy,
  output logic                  done,
  output logic                  pkt_err
);

  parser_state_e         state_q;
  logic [3:0]            len_q;
  logic [3:0]            cnt_q;
  logic [1:0]            widx_q;
  logic                  is_ann_q;
  logic [WORD_WIDTH-1:0] id_q;
  logic [WORD_WIDTH-1:0] hops_q;
  logic                  en_kch_q;
  logic                  hb_reset_q;
  logic [WORD_WIDTH-1:0] hb_limit_q;
  logic [WORD_WIDTH-1:0] fch_id_q;
  logic [WORD_WIDTH-1:0] fch_hops_q;
  logic [WORD_WIDTH-1:0] fch_q_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic                  fetch_start;
  logic [3:0]            fetch_len;
  logic [WORD_WIDTH-1:0] word;
  logic                  word_valid;

  // The done cycle (FINISH) already counts as not busy, so a new start is
  // taken there as well as in IDLE.
  assign fetch_start = start && (state_q == ST_IDLE || state_q == ST_FINISH);

  // Keep reading past the header only once it is known to be an announcement.
  always_comb begin
    fetch_len = len_q;
    if (state_q == ST_FETCH_HDR) begin
      fetch_len = (word_valid && word[15:8] == PKT_CH_ANNOUNCE) ? LEN_ANNOUNCE : LEN_SHORT;
    end
  end

  pkt_word_fetch #(
    .MEM_WIDTH  (MEM_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fetch (
    .clk          (clk),
    .nrst         (nrst),
    .start_i      (fetch_start),
    .base_addr_i  (base_addr),
    .len_i        (fetch_len),
    .mem_addr_o   (mem_addr),
    .mem_ren_o    (mem_ren),
    .mem_rdata_i  (mem_rdata),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Parser FSM: decode header, collect body words, then load outputs with
  // their strobe in a single edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      len_q      <= LEN_SHORT;
      cnt_q      <= 4'd0;
      widx_q     <= 2'd1;
      is_ann_q   <= 1'b0;
      id_q       <= '0;
      hops_q     <= '0;
      en_kch_q   <= 1'b0;
      hb_reset_q <= 1'b0;
      hb_limit_q <= '0;
      fch_id_q   <= '0;
      fch_hops_q <= HOPS_UNREACHABLE;
      fch_q_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      en_kch_q   <= 1'b0;
      hb_reset_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            state_q <= ST_FETCH_HDR;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
            widx_q  <= 2'd1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FETCH_HDR: begin
          cnt_q <= cnt_q + 4'd1;
          if (word_valid) begin
            if (word[15:8] == PKT_HEARTBEAT) begin
              len_q    <= LEN_SHORT;
              is_ann_q <= 1'b0;
              state_q  <= ST_FETCH_BODY;
            end else if (word[15:8] == PKT_CH_ANNOUNCE) begin
              len_q    <= LEN_ANNOUNCE;
              is_ann_q <= 1'b1;
              state_q  <= ST_FETCH_BODY;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FETCH_BODY: begin
          cnt_q <= cnt_q + 4'd1;
          if (word_valid) begin
            if (widx_q == 2'd1) id_q <= word;
            else                hops_q <= word;
            widx_q <= widx_q + 2'd1;
          end
          // cnt_q counts edges since start; it equals the packet length on
          // the edge capturing the final byte.
          if (cnt_q == len_q) state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_FINISH;
          if (is_ann_q) begin
            if (hops_q == HOPS_UNREACHABLE) begin
              err_q <= 1'b1;
            end else begin
              en_kch_q   <= 1'b1;
              fch_id_q   <= id_q;
              fch_hops_q <= hops_next(hops_q);
              fch_q_q    <= word;
            end
          end else begin
            hb_reset_q <= 1'b1;
            hb_limit_q <= word;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign en_KCH     = en_kch_q;
  assign HB_reset   = hb_reset_q;
  assign HB_CHlimit = hb_limit_q;
  assign fCH_ID     = fch_id_q;
  assign fCH_Hops   = fch_hops_q;
  assign fCH_QValue = fch_q_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pkt_err    = err_q;

endmodule

// File: tb/tb_rx_pkt_parser.sv
// tb/tb_rx_pkt_parser.sv - randomized self-checking bench for rx_pkt_parser
module tb_rx_pkt_parser;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] mem_addr;
  logic        mem_ren;
  logic [7:0]  mem_rdata;
  logic        en_KCH, HB_reset, busy, done, pkt_err;
  logic [15:0] HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue;

  logic [7:0]  mem [2048];

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_limit, m_id, m_hops, m_q;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

  rx_pkt_parser dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .base_addr  (base_addr),
    .mem_addr   (mem_addr),
    .mem_ren    (mem_ren),
    .mem_rdata  (mem_rdata),
    .en_KCH     (en_KCH),
    .HB_reset   (HB_reset),
    .HB_CHlimit (HB_CHlimit),
    .fCH_ID     (fCH_ID),
    .fCH_Hops   (fCH_Hops),
    .fCH_QValue (fCH_QValue),
    .busy       (busy),
    .done       (done),
    .pkt_err    (pkt_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_limit = 16'h0000;
    m_id    = 16'h0000;
    m_hops  = 16'hFFFF;
    m_q     = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string ctx);
    check_eq({ctx, " mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({ctx, " mem_ren"},  32'(mem_ren), 32'd0);
    check_eq({ctx, " en_KCH"},   32'(en_KCH), 32'd0);
    check_eq({ctx, " HB_reset"}, 32'(HB_reset), 32'd0);
    check_eq({ctx, " done"},     32'(done), 32'd0);
    check_eq({ctx, " busy"},     32'(busy), 32'd0);
    check_eq({ctx, " pkt_err"},  32'(pkt_err), 32'd0);
    check_eq({ctx, " HB_CHlimit"}, 32'(HB_CHlimit), 32'd0);
    check_eq({ctx, " fCH_ID"},   32'(fCH_ID), 32'd0);
    check_eq({ctx, " fCH_Hops"}, 32'(fCH_Hops), 32'h0000FFFF);
    check_eq({ctx, " fCH_QValue"}, 32'(fCH_QValue), 32'd0);
  endtask

  // Places a packet in memory, predicts the outcome from the packet rules,
  // runs one parse and compares timing, strobes, addresses and fields.
  task automatic run_pkt(input string tag, input logic [10:0] base, input logic [7:0] b [8],
                         input int spurious_at);
    int exp_done, exp_en, exp_hb, n_issue, exp_err, sh, hp;
    int got_done, got_en, got_hb, n_done, n_en, n_hb, bad_busy, bad_addr;
    for (int k = 0; k < 8; k++) mem[11'((int'(base) + k) % 2048)] = b[k];

    exp_en = -1; exp_hb = -1; exp_err = 0;
    if (b[0] == 8'h01) begin
      n_issue = 4; exp_done = 6; exp_hb = 6;
      m_limit = {b[2], b[3]};
    end else if (b[0] == 8'h02) begin
      n_issue = 8; exp_done = 10;
      sh = int'({b[4], b[5]});
      if (sh == 65535) begin
        exp_err = 1;
      end else begin
        exp_en = 10;
        hp = sh + 1;
        if (hp > 65534) hp = 65534;
        m_id = {b[2], b[3]}; m_hops = 16'(hp); m_q = {b[6], b[7]};
      end
    end else begin
      n_issue = 4; exp_done = 4; exp_err = 1;
    end

    got_done = -1; got_en = -1; got_hb = -1;
    n_done = 0; n_en = 0; n_hb = 0; bad_busy = 0; bad_addr = 0;
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < n_issue) begin
        if (mem_ren !== 1'b1 || mem_addr !== 11'((int'(base) + i) % 2048)) bad_addr++;
      end else if (mem_ren !== 1'b0) begin
        bad_addr++;
      end
      if (busy !== (i < exp_done)) bad_busy++;
      if (done === 1'b1)     begin n_done++; if (got_done < 0) got_done = i; end
      if (en_KCH === 1'b1)   begin n_en++;   if (got_en < 0)   got_en = i;   end
      if (HB_reset === 1'b1) begin n_hb++;   if (got_hb < 0)   got_hb = i;   end
      if (i == spurious_at) begin
        start = 1'b1;
        base_addr = base + 11'd100;
      end else if (i == spurious_at + 1) begin
        start = 1'b0;
      end
    end

    check_eq({tag, " done_edge"}, got_done, exp_done);
    check_eq({tag, " done_count"}, n_done, 1);
    check_eq({tag, " en_edge"}, got_en, exp_en);
    check_eq({tag, " en_count"}, n_en, (exp_en >= 0) ? 1 : 0);
    check_eq({tag, " hb_edge"}, got_hb, exp_hb);
    check_eq({tag, " hb_count"}, n_hb, (exp_hb >= 0) ? 1 : 0);
    check_eq({tag, " busy_profile_errs"}, bad_busy, 0);
    check_eq({tag, " addr_seq_errs"}, bad_addr, 0);
    check_eq({tag, " pkt_err"}, 32'(pkt_err), exp_err);
    check_eq({tag, " HB_CHlimit"}, 32'(HB_CHlimit), 32'(m_limit));
    check_eq({tag, " fCH_ID"}, 32'(fCH_ID), 32'(m_id));
    check_eq({tag, " fCH_Hops"}, 32'(fCH_Hops), 32'(m_hops));
    check_eq({tag, " fCH_QValue"}, 32'(fCH_QValue), 32'(m_q));
  endtask

  initial begin
    logic [7:0]  pkt [8];
    logic [10:0] rb;
    logic [15:0] sh;
    int r, t, saw_en;

    nrst = 1'b0;
    start = 1'b0;
    base_addr = '0;
    for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    nrst = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    pkt = '{8'h01, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    run_pkt("hb_base16", 11'd16, pkt, -1);
    pkt = '{8'h02, 8'h00, 8'h00, 8'h07, 8'h00, 8'h02, 8'h01, 8'hF4};
    run_pkt("ann_wrap", 11'd2044, pkt, -1);
    pkt = '{8'h02, 8'h55, 8'h00, 8'h09, 8'hFF, 8'hFE, 8'h12, 8'h34};
    run_pkt("hops_fffe", 11'd500, pkt, -1);
    pkt = '{8'h02, 8'h00, 8'h00, 8'h0B, 8'hFF, 8'hFF, 8'h00, 8'h01};
    run_pkt("hops_ffff", 11'd600, pkt, -1);
    pkt = '{8'h7F, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    run_pkt("unknown_7f", 11'd700, pkt, 1);

    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      rb = 11'($urandom_range(0, 2047));
      for (int k = 0; k < 8; k++) pkt[k] = 8'($urandom);
      if (r < 4) begin
        pkt[0] = 8'h01;
      end else if (r < 8) begin
        pkt[0] = 8'h02;
        case ($urandom_range(0, 4))
          0: sh = 16'hFFFF;
          1: sh = 16'hFFFE;
          2: sh = 16'hFFFD;
          3: sh = 16'h0000;
          default: sh = 16'($urandom);
        endcase
        pkt[4] = sh[15:8];
        pkt[5] = sh[7:0];
      end else begin
        t = $urandom_range(0, 255);
        if (t == 1 || t == 2) t = 8'h80;
        pkt[0] = 8'(t);
      end
      run_pkt($sformatf("rand%0d", n), rb, pkt, ($urandom_range(0, 3) == 0) ? 2 : -1);
    end

    pkt = '{8'h02, 8'h00, 8'h00, 8'h21, 8'h00, 8'h04, 8'h00, 8'h63};
    for (int k = 0; k < 8; k++) mem[300 + k] = pkt[k];
    @(negedge clk);
    base_addr = 11'd300;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 nrst = 1'b0;
    saw_en = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (en_KCH === 1'b1) saw_en++;
    end
    check_eq("abort en_KCH_seen", saw_en, 0);
    model_reset();
    check_reset_outputs("abort");
    nrst = 1'b1;
    pkt = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
    run_pkt("hb_after_abort", 11'd900, pkt, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
